// File: rtl/ahb_master_mux.sv
// Purpose : N-channel user front end for the AHB master core; round-robin burst ownership,
//           command forwarding to the core and in-order read-response routing by tag FIFO.
// Latency : commands pass combinationally from the owner to the core (1 arbitration cycle
//           before the first beat of a burst); read responses reach o_dav 1 cycle after i_core_dav.
// Backpressure: o_stall[c] is 1 for every non-owner, and for the owner when i_core_next=0,
//           when the tag FIFO is full on a read beat, or when it is preempted at a burst start.
//
// Ports:
//   i_hclk / i_hreset_n            clock, asynchronous active-low reset
//   o_stall, i_idle, i_wr_data, i_wr_data_dav, i_addr, i_size, i_wr, i_rd, i_min_len,
//   i_first_xfer                   per-channel user command ports (channel c in slice c)
//   o_data, o_addr, o_dav          per-channel read responses (registered)
//   o_core_*                       command to the core, i_core_next = core accepts
//   i_core_data/addr/dav           in-order read responses from the core
//   o_err                          sticky: response arrived with no outstanding read
module ahb_master_mux #(
   parameter int NUM_CH    = 2,
   parameter int DATA_WDT  = 32,
   parameter int BEAT_WDT  = 32,
   parameter int RSP_DEPTH = 8
) (
   input  logic                         i_hclk,
   input  logic                         i_hreset_n,
   output logic [NUM_CH-1:0]            o_stall,
   input  logic [NUM_CH-1:0]            i_idle,
   input  logic [NUM_CH*DATA_WDT-1:0]   i_wr_data,
   input  logic [NUM_CH-1:0]            i_wr_data_dav,
   input  logic [NUM_CH*32-1:0]         i_addr,
   input  logic [NUM_CH*3-1:0]          i_size,
   input  logic [NUM_CH-1:0]            i_wr,
   input  logic [NUM_CH-1:0]            i_rd,
   input  logic [NUM_CH*BEAT_WDT-1:0]   i_min_len,
   input  logic [NUM_CH-1:0]            i_first_xfer,
   output logic [NUM_CH*DATA_WDT-1:0]   o_data,
   output logic [NUM_CH*32-1:0]         o_addr,
   output logic [NUM_CH-1:0]            o_dav,
   output logic [DATA_WDT-1:0]          o_core_data,
   output logic                         o_core_dav,
   output logic [31:0]                  o_core_addr,
   output logic [2:0]                   o_core_size,
   output logic                         o_core_wr,
   output logic                         o_core_rd,
   output logic [BEAT_WDT-1:0]          o_core_min_len,
   output logic                         o_core_cont,
   input  logic                         i_core_next,
   input  logic [DATA_WDT-1:0]          i_core_data,
   input  logic [31:0]                  i_core_addr,
   input  logic                         i_core_dav,
   output logic                         o_err
);

   localparam int TAG_W = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_ARB = 1'b0;
   localparam logic [0:0] ST_OWN = 1'b1;

   logic [0:0]        state;
   logic [TAG_W-1:0]  owner;
   logic [TAG_W-1:0]  rr_ptr;

   // ------------------------------------------------------------------
   // Round-robin arbitration
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] req;
   logic [TAG_W-1:0]  grant;
   logic              grant_vld;
   logic [TAG_W-1:0]  scan_idx;

   assign req = i_first_xfer & ~i_idle;

   // Walk the channels starting just after the last winner, wrapping at NUM_CH
   // (which need not be a power of two).
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      scan_idx  = rr_ptr;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = (scan_idx == TAG_W'(NUM_CH - 1)) ? '0 : scan_idx + TAG_W'(1);
         if (!grant_vld && req[scan_idx]) begin
            grant_vld = 1'b1;
            grant     = scan_idx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Owner field selection
   // ------------------------------------------------------------------
   logic                own_idle;
   logic                own_first;
   logic                own_wr;
   logic                own_rd;
   logic                own_wdav;
   logic [DATA_WDT-1:0] own_data;
   logic [31:0]         own_addr;
   logic [2:0]          own_size;
   logic [BEAT_WDT-1:0] own_min_len;

   assign own_idle    = i_idle[owner];
   assign own_first   = i_first_xfer[owner];
   assign own_wr      = i_wr[owner];
   assign own_rd      = i_rd[owner];
   assign own_wdav    = i_wr_data_dav[owner];
   assign own_data    = i_wr_data[owner*DATA_WDT +: DATA_WDT];
   assign own_addr    = i_addr[owner*32 +: 32];
   assign own_size    = i_size[owner*3 +: 3];
   assign own_min_len = i_min_len[owner*BEAT_WDT +: BEAT_WDT];

   // ------------------------------------------------------------------
   // Tag FIFO status (needed by the forwarding logic)
   // ------------------------------------------------------------------
   logic [CNT_W-1:0]  tag_cnt;
   logic              tag_full;
   logic              tag_empty;

   assign tag_full  = (tag_cnt == CNT_W'(RSP_DEPTH));
   assign tag_empty = (tag_cnt == '0);

   // ------------------------------------------------------------------
   // Command forwarding
   // ------------------------------------------------------------------
   logic other_req;
   logic preempt;
   logic fwd;
   logic rd_beat;

   assign other_req = |(req & ~(NUM_CH'(1) << owner));

   // A new burst start from the owner while someone else is waiting gives the
   // bus up instead of forwarding the beat: the owner re-enters arbitration.
   assign preempt = (state == ST_OWN) & i_core_next & own_first & ~own_idle & other_req;
   assign fwd     = (state == ST_OWN) & ~preempt;
   assign rd_beat = own_rd & ~own_idle;

   assign o_core_wr      = fwd & own_wr & ~own_idle;
   // With the tag FIFO full the read is gapped: rd drops but cont keeps the burst open.
   assign o_core_rd      = fwd & rd_beat & ~tag_full;
   assign o_core_cont    = fwd & ~(own_idle | own_first);
   assign o_core_dav     = fwd & own_wdav;
   assign o_core_data    = fwd ? own_data    : '0;
   assign o_core_addr    = fwd ? own_addr    : '0;
   assign o_core_size    = fwd ? own_size    : '0;
   assign o_core_min_len = fwd ? own_min_len : '0;

   always_comb begin
      o_stall = '1;
      if (fwd) begin
         o_stall[owner] = ~i_core_next | (rd_beat & tag_full);
      end
   end

   // ------------------------------------------------------------------
   // Ownership state
   // ------------------------------------------------------------------
   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n) begin
         state  <= ST_ARB;
         owner  <= '0;
         rr_ptr <= TAG_W'(NUM_CH - 1);
      end else begin
         case (state)
            ST_ARB: begin
               if (grant_vld) begin
                  state  <= ST_OWN;
                  owner  <= grant;
                  rr_ptr <= grant;
               end
            end
            ST_OWN: begin
               if (i_core_next && (own_idle || preempt)) begin
                  state <= ST_ARB;
               end
            end
            default: state <= ST_ARB;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Tag FIFO: one entry per accepted read beat, holding the issuing channel
   // ------------------------------------------------------------------
   logic [TAG_W-1:0] tag_mem [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [TAG_W-1:0] head;

   assign push = o_core_rd & i_core_next;
   assign pop  = i_core_dav & ~tag_empty;
   assign head = tag_mem[rd_ptr];

   always_ff @(posedge i_hclk) begin
      if (push) begin
         tag_mem[wr_ptr] <= owner;
      end
   end

   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
            2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Response routing; non-selected data slices keep their last value
   // ------------------------------------------------------------------
   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n) begin
         o_dav  <= '0;
         o_data <= '0;
         o_addr <= '0;
         o_err  <= 1'b0;
      end else begin
         o_dav <= '0;
         if (pop) begin
            o_dav[head]                         <= 1'b1;
            o_data[head*DATA_WDT +: DATA_WDT]   <= i_core_data;
            o_addr[head*32 +: 32]               <= i_core_addr;
         end
         if (i_core_dav && tag_empty) begin
            o_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ahb_master_mux.sv
`timescale 1ns/1ps
module tb_ahb_master_mux;
   localparam int N  = 3;
   localparam int DW = 32;
   localparam int BW = 32;
   localparam int D  = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     o_stall, i_idle, i_wr_data_dav, i_wr, i_rd, i_first_xfer, o_dav;
   logic [N*DW-1:0]  i_wr_data, o_data;
   logic [N*32-1:0]  i_addr, o_addr;
   logic [N*3-1:0]   i_size;
   logic [N*BW-1:0]  i_min_len;
   logic [DW-1:0]    o_core_data, i_core_data;
   logic             o_core_dav, o_core_wr, o_core_rd, o_core_cont, i_core_next, i_core_dav, o_err;
   logic [31:0]      o_core_addr, i_core_addr;
   logic [2:0]       o_core_size;
   logic [BW-1:0]    o_core_min_len;

   always #5 clk = ~clk;

   ahb_master_mux #(.NUM_CH(N), .DATA_WDT(DW), .BEAT_WDT(BW), .RSP_DEPTH(D)) dut (
      .i_hclk(clk), .i_hreset_n(rst_n), .o_stall(o_stall), .i_idle(i_idle),
      .i_wr_data(i_wr_data), .i_wr_data_dav(i_wr_data_dav), .i_addr(i_addr), .i_size(i_size),
      .i_wr(i_wr), .i_rd(i_rd), .i_min_len(i_min_len), .i_first_xfer(i_first_xfer),
      .o_data(o_data), .o_addr(o_addr), .o_dav(o_dav), .o_core_data(o_core_data),
      .o_core_dav(o_core_dav), .o_core_addr(o_core_addr), .o_core_size(o_core_size),
      .o_core_wr(o_core_wr), .o_core_rd(o_core_rd), .o_core_min_len(o_core_min_len),
      .o_core_cont(o_core_cont), .i_core_next(i_core_next), .i_core_data(i_core_data),
      .i_core_addr(i_core_addr), .i_core_dav(i_core_dav), .o_err(o_err));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: owner index (-1 = nobody), last winner, queue of
   // outstanding read tags, expected registered response outputs.
   // ------------------------------------------------------------------
   int          m_own;
   int          m_rr;
   int          m_q[$];
   bit          m_err;
   logic [N-1:0] m_dav;
   logic [DW-1:0] m_data[N];
   logic [31:0]  m_addr[N];
   bit           m_known[N];

   logic [N-1:0] e_stall, rq;
   logic         e_wr, e_rd, e_cont, e_cdav, full, others, pre, rdb, pushed;
   logic [DW-1:0] e_data;
   logic [31:0]  e_addr;
   logic [2:0]   e_size;
   logic [BW-1:0] e_len;
   int           nxt_own, o, t, cand;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_own = -1; m_rr = N - 1; m_q.delete(); m_err = 0; m_dav = '0;
         for (int c = 0; c < N; c++) m_known[c] = 0;
         chk("rst_stall", o_stall, {N{1'b1}});
         chk("rst_err", o_err, 1'b0);
         chk("rst_dav", o_dav, '0);
         chk("rst_core_rd", o_core_rd, 1'b0);
      end else begin
         e_stall = '1; e_wr = 0; e_rd = 0; e_cont = 0; e_cdav = 0;
         e_data = '0; e_addr = '0; e_size = '0; e_len = '0; pushed = 0;
         full = (m_q.size() == D);
         for (int c = 0; c < N; c++) rq[c] = i_first_xfer[c] && !i_idle[c];
         nxt_own = m_own;
         o = m_own;
         if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
               cand = (m_rr + k) % N;
               if (nxt_own < 0 && rq[cand]) nxt_own = cand;
            end
            if (nxt_own >= 0) m_rr = nxt_own;
         end else begin
            others = 0;
            for (int c = 0; c < N; c++) if (c != o && rq[c]) others = 1;
            pre = i_core_next && i_first_xfer[o] && !i_idle[o] && others;
            if (!pre) begin
               rdb    = i_rd[o] && !i_idle[o];
               e_wr   = i_wr[o] && !i_idle[o];
               e_rd   = rdb && !full;
               e_cont = !(i_idle[o] || i_first_xfer[o]);
               e_cdav = i_wr_data_dav[o];
               e_data = i_wr_data[o*DW +: DW];
               e_addr = i_addr[o*32 +: 32];
               e_size = i_size[o*3 +: 3];
               e_len  = i_min_len[o*BW +: BW];
               e_stall[o] = !i_core_next || (rdb && full);
            end
            if (i_core_next && (i_idle[o] || pre)) nxt_own = -1;
            pushed = e_rd && i_core_next;
         end
         chk("stall", o_stall, e_stall);
         chk("core_wr", o_core_wr, e_wr);
         chk("core_rd", o_core_rd, e_rd);
         chk("core_cont", o_core_cont, e_cont);
         chk("core_dav", o_core_dav, e_cdav);
         chk("core_data", o_core_data, e_data);
         chk("core_addr", o_core_addr, e_addr);
         chk("core_size", o_core_size, e_size);
         chk("core_min_len", o_core_min_len, e_len);
         chk("rsp_dav", o_dav, m_dav);
         chk("err", o_err, m_err);
         for (int c = 0; c < N; c++) if (m_known[c]) begin
            chk("rsp_data", o_data[c*DW +: DW], m_data[c]);
            chk("rsp_addr", o_addr[c*32 +: 32], m_addr[c]);
         end
         // advance the model by one clock
         m_dav = '0;
         if (i_core_dav) begin
            if (m_q.size() > 0) begin
               t = m_q.pop_front();
               m_dav[t] = 1'b1; m_data[t] = i_core_data; m_addr[t] = i_core_addr; m_known[t] = 1;
            end else m_err = 1;
         end
         if (pushed) m_q.push_back(o);
         m_own = nxt_own;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change at posedge+1, literal checks at negedge+1
   // ------------------------------------------------------------------
   task automatic tick(); @(posedge clk); #1; endtask
   task automatic look(); @(negedge clk); #1; endtask
   task automatic idle_all();
      i_idle = '1; i_first_xfer = '0; i_rd = '0; i_wr = '0; i_wr_data_dav = '0; i_core_dav = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0; idle_all(); tick(); tick(); rst_n = 1'b1;
   endtask

   int r;

   initial begin
      i_wr_data = '0; i_addr = '0; i_size = '0; i_min_len = '0;
      i_core_next = 1'b0; i_core_data = '0; i_core_addr = '0;
      idle_all();

      // --- single channel read of 4 beats, responses routed to ch0
      do_reset();
      look(); chk("t1_reset_stall", o_stall, 3'b111); chk("t1_reset_err", o_err, 1'b0);
      tick();
      i_idle[0] = 0; i_first_xfer[0] = 1; i_rd[0] = 1; i_addr[31:0] = 32'h100; i_core_next = 1;
      look(); chk("t1_req_stall", o_stall[0], 1'b1); chk("t1_req_rd", o_core_rd, 1'b0);
      tick();
      for (int b = 0; b < 4; b++) begin
         i_addr[31:0] = 32'h100 + 32'(4*b); i_first_xfer[0] = (b == 0);
         look(); chk("t1_rd", o_core_rd, 1'b1); chk("t1_cont", o_core_cont, b != 0);
         chk("t1_addr", o_core_addr, 32'h100 + 32'(4*b)); chk("t1_stall", o_stall[0], 1'b0);
         tick();
      end
      i_idle[0] = 1; i_rd[0] = 0; i_first_xfer[0] = 0;
      look(); tick();
      for (int k = 0; k <= 4; k++) begin
         i_core_dav = (k < 4); i_core_data = 32'h100 + 32'(4*k); i_core_addr = 32'h100 + 32'(4*k);
         look();
         if (k > 0) begin
            chk("t1_rsp_dav", o_dav, 3'b001);
            chk("t1_rsp_data", o_data[31:0], 32'h100 + 32'(4*(k-1)));
         end
         tick();
      end
      i_core_dav = 0;
      look(); chk("t1_rsp_done", o_dav, 3'b000); tick();

      // --- tie from reset, then release hand-over, then second tie
      do_reset();
      i_idle[1:0] = 2'b00; i_first_xfer[1:0] = 2'b11; i_wr[1:0] = 2'b11;
      look(); tick();
      i_first_xfer[0] = 0;
      look(); chk("t2_grant0", o_stall, 3'b110); chk("t2_wr", o_core_wr, 1'b1); tick();
      i_idle[0] = 1; i_wr[0] = 0;
      look(); tick();
      look(); chk("t2_arb", o_stall, 3'b111); tick();
      i_first_xfer[1] = 0;
      look(); chk("t2_grant1", o_stall, 3'b101); tick();
      i_idle[1] = 1; i_wr[1] = 0;
      look(); tick();
      i_idle[1:0] = 2'b00; i_first_xfer[1:0] = 2'b11; i_wr[1:0] = 2'b11;
      look(); tick();
      i_first_xfer[0] = 0;
      look(); chk("t2_grant0_again", o_stall, 3'b110); tick();

      // --- owner reissues burst start while ch1 waits: preempted
      i_first_xfer[0] = 1;
      look(); chk("t3_pre_stall", o_stall, 3'b111); chk("t3_pre_wr", o_core_wr, 1'b0);
      chk("t3_pre_cont", o_core_cont, 1'b0); tick();
      look(); tick();
      i_first_xfer[1] = 0;
      look(); chk("t3_grant1", o_stall, 3'b101); tick();
      look(); chk("t3_ch0_held", o_stall, 3'b101); tick();
      i_idle[1] = 1; i_wr[1] = 0;
      look(); tick();
      look(); tick();
      look(); chk("t3_resume0", o_stall, 3'b110); chk("t3_resume_cont", o_core_cont, 1'b0); tick();
      idle_all(); look(); tick();

      // --- tag FIFO full: 9th read beat gapped
      do_reset();
      i_idle[0] = 0; i_first_xfer[0] = 1; i_rd[0] = 1; i_core_next = 1;
      look(); tick();
      for (int b = 1; b <= 8; b++) begin
         look(); chk("t4_rd", o_core_rd, 1'b1); tick(); i_first_xfer[0] = 0;
      end
      look(); chk("t4_full_rd", o_core_rd, 1'b0); chk("t4_full_cont", o_core_cont, 1'b1);
      chk("t4_full_stall", o_stall[0], 1'b1); tick();
      i_core_dav = 1;
      look(); chk("t4_pop_cycle_rd", o_core_rd, 1'b0); tick();
      i_core_dav = 0;
      look(); chk("t4_unblock_rd", o_core_rd, 1'b1); tick();
      i_idle[0] = 1; i_rd[0] = 0;
      look(); tick();
      i_core_dav = 1;
      for (int k = 0; k < 8; k++) tick();
      i_core_dav = 0;
      look(); chk("t4_no_err", o_err, 1'b0); tick();

      // --- response with nothing outstanding; reset mid-burst drops tags
      do_reset();
      i_core_dav = 1; look(); tick();
      i_core_dav = 0;
      look(); chk("t6_err", o_err, 1'b1); chk("t6_no_dav", o_dav, 3'b000); tick(); tick();
      look(); chk("t6_err_hold", o_err, 1'b1); tick();
      i_idle[0] = 0; i_first_xfer[0] = 1; i_rd[0] = 1;
      look(); tick(); look(); tick(); look(); tick();
      rst_n = 0; #1;
      chk("t6_rst_stall", o_stall, 3'b111); chk("t6_rst_err", o_err, 1'b0);
      idle_all(); tick(); rst_n = 1;
      i_core_dav = 1; look(); tick();
      i_core_dav = 0; look(); chk("t6_tags_dropped", o_err, 1'b1); tick();

      // --- randomized traffic, model checks every cycle
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         for (int cy = 0; cy < 400; cy++) begin
            for (int c = 0; c < N; c++) begin
               i_idle[c]       = ($urandom % 5) == 0;
               i_first_xfer[c] = ($urandom % 6) == 0;
               r = int'($urandom % 3);
               i_rd[c] = (r == 0); i_wr[c] = (r == 1);
               i_wr_data_dav[c] = 1'($urandom);
               i_wr_data[c*DW +: DW] = $urandom;
               i_addr[c*32 +: 32]    = $urandom;
               i_size[c*3 +: 3]      = 3'($urandom);
               i_min_len[c*BW +: BW] = $urandom;
            end
            i_core_next = ($urandom % 4) != 0;
            i_core_data = $urandom; i_core_addr = $urandom;
            if (seg % 3 == 2) i_core_dav = ($urandom % 5) == 0;
            else              i_core_dav = (m_q.size() > 0) && (($urandom % 3) == 0);
            tick();
         end
      end
      idle_all(); look();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
